// File: rtl/exec_mem_datapath.sv
// ---------------------------------------------------------------------------
// exec_mem_datapath
// Execute/memory slice of the 5-stage pipeline: a combinational 32-bit ALU
// with zero/negative flags, a PC+4 incrementer and a 512-byte big-endian
// data memory with byte/halfword/word access.
//
// Ports
//   clk       in   system clock (memory writes and reset on rising edge)
//   reset     in   synchronous active-high, zeroes the whole data memory
//   alu_a/b   in   ALU operands
//   alu_op    in   ALU operation select
//   alu_out   out  ALU result; alu_z = (alu_out == 0), alu_n = alu_out[31]
//   pc_in     in   current nPC value; pc_plus4 = pc_in + 4
//   mem_addr  in   byte address (wraps modulo 512 for multi-byte accesses)
//   mem_di    in   write data, right-justified for byte/halfword
//   mem_size  in   00 byte, 01 halfword, 10/11 word
//   mem_rw    in   0 read, 1 write
//   mem_en    in   memory enable
//   mem_se    in   sign-extend byte/halfword reads
//   mem_do    out  combinational read data, 0 unless enabled read
// ---------------------------------------------------------------------------
module exec_mem_datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [3:0]  alu_op,
    output logic [31:0] alu_out,
    output logic        alu_z,
    output logic        alu_n,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_plus4,
    input  logic [8:0]  mem_addr,
    input  logic [31:0] mem_di,
    input  logic [1:0]  mem_size,
    input  logic        mem_rw,
    input  logic        mem_en,
    input  logic        mem_se,
    output logic [31:0] mem_do
);

    // Byte-addressed storage; name kept as mem so benches can preload it.
    logic [7:0] mem [0:511];

    logic [4:0] w_shamt;
    logic [8:0] w_a0;
    logic [8:0] w_a1;
    logic [8:0] w_a2;
    logic [8:0] w_a3;
    logic [7:0] w_b0;
    logic [7:0] w_b1;
    logic [7:0] w_b2;
    logic [7:0] w_b3;

    // Extend a byte to 32 bits, with sign or zeros.
    function automatic logic [31:0] ext8(input logic [7:0] v, input logic se);
        return {{24{se & v[7]}}, v};
    endfunction

    // Extend a halfword to 32 bits, with sign or zeros.
    function automatic logic [31:0] ext16(input logic [15:0] v, input logic se);
        return {{16{se & v[15]}}, v};
    endfunction

    assign w_shamt = alu_a[4:0];

    // 9-bit sums wrap naturally at the top of the 512-byte array.
    assign w_a0 = mem_addr;
    assign w_a1 = mem_addr + 9'd1;
    assign w_a2 = mem_addr + 9'd2;
    assign w_a3 = mem_addr + 9'd3;

    assign w_b0 = mem[w_a0];
    assign w_b1 = mem[w_a1];
    assign w_b2 = mem[w_a2];
    assign w_b3 = mem[w_a3];

    // ALU operation decode.
    always_comb begin
        alu_out = 32'd0;
        case (alu_op)
            4'b0000: alu_out = alu_a + alu_b;
            4'b0001: alu_out = alu_a - alu_b;
            4'b0010: alu_out = alu_a & alu_b;
            4'b0011: alu_out = alu_a | alu_b;
            4'b0100: alu_out = alu_a ^ alu_b;
            4'b0101: alu_out = ~(alu_a | alu_b);
            4'b0110: alu_out = alu_b << w_shamt;
            4'b0111: alu_out = alu_b >> w_shamt;
            4'b1000: alu_out = $unsigned($signed(alu_b) >>> w_shamt);
            4'b1001: alu_out = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            4'b1010: alu_out = {31'd0, (alu_a < alu_b)};
            4'b1011: alu_out = alu_a;
            4'b1100: alu_out = alu_b;
            4'b1101: alu_out = alu_a + 32'd8;
            default: alu_out = 32'd0;
        endcase
    end

    assign alu_z    = (alu_out == 32'd0);
    assign alu_n    = alu_out[31];
    assign pc_plus4 = pc_in + 32'd4;

    // Big-endian read mux; bytes at mem_addr land in the most significant lane.
    always_comb begin
        mem_do = 32'd0;
        if (mem_en && !mem_rw) begin
            case (mem_size)
                2'b00:   mem_do = ext8(w_b0, mem_se);
                2'b01:   mem_do = ext16({w_b0, w_b1}, mem_se);
                default: mem_do = {w_b0, w_b1, w_b2, w_b3};
            endcase
        end else begin
            mem_do = 32'd0;
        end
    end

    // Memory update: reset clears everything and overrides any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 512; i++) begin
                mem[i] <= 8'd0;
            end
        end else if (mem_en && mem_rw) begin
            case (mem_size)
                2'b00: begin
                    mem[w_a0] <= mem_di[7:0];
                end
                2'b01: begin
                    mem[w_a0] <= mem_di[15:8];
                    mem[w_a1] <= mem_di[7:0];
                end
                default: begin
                    mem[w_a0] <= mem_di[31:24];
                    mem[w_a1] <= mem_di[23:16];
                    mem[w_a2] <= mem_di[15:8];
                    mem[w_a3] <= mem_di[7:0];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_mem_datapath.sv
// ---------------------------------------------------------------------------
// tb_exec_mem_datapath
// Directed self-checking bench for exec_mem_datapath. Each vector carries a
// hand-computed expected value; every comparison goes through check_val.
// ---------------------------------------------------------------------------
module tb_exec_mem_datapath;

    logic        clk;
    logic        reset;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;
    logic        alu_z;
    logic        alu_n;
    logic [31:0] pc_in;
    logic [31:0] pc_plus4;
    logic [8:0]  mem_addr;
    logic [31:0] mem_di;
    logic [1:0]  mem_size;
    logic        mem_rw;
    logic        mem_en;
    logic        mem_se;
    logic [31:0] mem_do;

    int n_checks_r;
    int n_pass_r;

    exec_mem_datapath dut (
        .clk      (clk),
        .reset    (reset),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_out  (alu_out),
        .alu_z    (alu_z),
        .alu_n    (alu_n),
        .pc_in    (pc_in),
        .pc_plus4 (pc_plus4),
        .mem_addr (mem_addr),
        .mem_di   (mem_di),
        .mem_size (mem_size),
        .mem_rw   (mem_rw),
        .mem_en   (mem_en),
        .mem_se   (mem_se),
        .mem_do   (mem_do)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks_r++;
        if (got === exp) begin
            n_pass_r++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic alu_chk(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        alu_op = op;
        alu_a  = a;
        alu_b  = b;
        #1;
        check_val(tag, alu_out, exp);
    endtask

    // Write one access on the next rising edge, then return to idle.
    task automatic mem_write(input logic [8:0] addr, input logic [31:0] data, input logic [1:0] size);
        @(negedge clk);
        mem_addr = addr;
        mem_di   = data;
        mem_size = size;
        mem_rw   = 1'b1;
        mem_en   = 1'b1;
        @(posedge clk);
        #1;
        mem_en   = 1'b0;
        mem_rw   = 1'b0;
    endtask

    task automatic mem_read(input string tag, input logic [8:0] addr, input logic [1:0] size,
                            input logic se, input logic [31:0] exp);
        mem_addr = addr;
        mem_size = size;
        mem_se   = se;
        mem_rw   = 1'b0;
        mem_en   = 1'b1;
        #1;
        check_val(tag, mem_do, exp);
        mem_en   = 1'b0;
    endtask

    initial begin
        n_checks_r = 0;
        n_pass_r   = 0;
        reset    = 1'b1;
        alu_a    = 32'd0;
        alu_b    = 32'd0;
        alu_op   = 4'd0;
        pc_in    = 32'd0;
        mem_addr = 9'd0;
        mem_di   = 32'd0;
        mem_size = 2'b10;
        mem_rw   = 1'b0;
        mem_en   = 1'b0;
        mem_se   = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state of the memory.
        mem_read("rst_word8",   9'd8,   2'b10, 1'b0, 32'h0000_0000);
        mem_read("rst_word508", 9'd508, 2'b10, 1'b0, 32'h0000_0000);

        // ALU sweep.
        alu_chk("add_5_3",  4'b0000, 32'd5, 32'd3, 32'd8);
        alu_chk("sub_5_3",  4'b0001, 32'd5, 32'd3, 32'd2);
        alu_chk("slt_5_3",  4'b1001, 32'd5, 32'd3, 32'd0);
        alu_chk("sub_3_5",  4'b0001, 32'd3, 32'd5, 32'hFFFF_FFFE);
        check_val("sub_3_5_n", {31'd0, alu_n}, 32'd1);
        check_val("sub_3_5_z", {31'd0, alu_z}, 32'd0);
        alu_chk("sra_4",    4'b1000, 32'd4, 32'hF000_0000, 32'hFF00_0000);
        alu_chk("srl_4",    4'b0111, 32'd4, 32'hF000_0000, 32'h0F00_0000);
        alu_chk("sub_7_7",  4'b0001, 32'd7, 32'd7, 32'd0);
        check_val("sub_7_7_z", {31'd0, alu_z}, 32'd1);
        check_val("sub_7_7_n", {31'd0, alu_n}, 32'd0);
        alu_chk("and",      4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
        alu_chk("or",       4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
        alu_chk("xor",      4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
        alu_chk("nor",      4'b0101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F);
        alu_chk("sll_4",    4'b0110, 32'd4, 32'h0000_000F, 32'h0000_00F0);
        alu_chk("sll_shamt_lsb", 4'b0110, 32'h0000_0024, 32'd1, 32'h0000_0010);
        alu_chk("slt_neg",  4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu_chk("sltu_neg", 4'b1010, 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu_chk("sltu_lt",  4'b1010, 32'd1, 32'hFFFF_FFFF, 32'd1);
        alu_chk("pass_a",   4'b1011, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_5678);
        alu_chk("pass_b",   4'b1100, 32'h1234_5678, 32'h9ABC_DEF0, 32'h9ABC_DEF0);
        alu_chk("a_plus8",  4'b1101, 32'hFFFF_FFFC, 32'd0, 32'h0000_0004);
        alu_chk("op_e",     4'b1110, 32'h1234_5678, 32'h1, 32'd0);
        alu_chk("op_f",     4'b1111, 32'h1234_5678, 32'h1, 32'd0);

        // Incrementer.
        pc_in = 32'd0;
        #1;
        check_val("pc_0", pc_plus4, 32'd4);
        pc_in = 32'hFFFF_FFFC;
        #1;
        check_val("pc_wrap", pc_plus4, 32'd0);
        pc_in = 32'h0040_0010;
        #1;
        check_val("pc_mid", pc_plus4, 32'h0040_0014);

        // Word write and sub-word reads.
        mem_write(9'd8, 32'hAABB_CCDD, 2'b10);
        mem_read("wr_word8",    9'd8,  2'b10, 1'b0, 32'hAABB_CCDD);
        mem_read("size11_word", 9'd8,  2'b11, 1'b0, 32'hAABB_CCDD);
        mem_read("byte8_se",    9'd8,  2'b00, 1'b1, 32'hFFFF_FFAA);
        mem_read("byte9_ze",    9'd9,  2'b00, 1'b0, 32'h0000_00BB);
        mem_read("half10_se",   9'd10, 2'b01, 1'b1, 32'hFFFF_CCDD);
        mem_read("half10_ze",   9'd10, 2'b01, 1'b0, 32'h0000_CCDD);

        // Read data is zero while a write is presented.
        mem_addr = 9'd8;
        mem_size = 2'b10;
        mem_en   = 1'b1;
        mem_rw   = 1'b1;
        #1;
        check_val("do_zero_on_rw", mem_do, 32'd0);
        mem_en   = 1'b0;
        mem_rw   = 1'b0;

        // Partial writes.
        mem_write(9'd9, 32'hFFFF_FF12, 2'b00);
        mem_read("byte_wr_word8", 9'd8, 2'b10, 1'b0, 32'hAA12_CCDD);
        mem_write(9'd0, 32'h1122_3344, 2'b10);
        mem_write(9'd510, 32'hFFFF_3344, 2'b01);
        mem_read("half_wrap", 9'd510, 2'b10, 1'b0, 32'h3344_1122);
        mem_read("word0_kept", 9'd0, 2'b10, 1'b0, 32'h1122_3344);

        // Disabled write leaves memory untouched and reads 0.
        @(negedge clk);
        mem_addr = 9'd8;
        mem_di   = 32'hDEAD_BEEF;
        mem_size = 2'b10;
        mem_rw   = 1'b1;
        mem_en   = 1'b0;
        #1;
        check_val("dis_do_zero", mem_do, 32'd0);
        @(posedge clk);
        #1;
        mem_rw = 1'b0;
        check_val("dis_do_zero_rd", mem_do, 32'd0);
        mem_read("dis_kept", 9'd8, 2'b10, 1'b0, 32'hAA12_CCDD);

        // Reset during a write wins and clears the array.
        @(negedge clk);
        reset    = 1'b1;
        mem_addr = 9'd8;
        mem_di   = 32'h5555_5555;
        mem_size = 2'b10;
        mem_rw   = 1'b1;
        mem_en   = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mem_en = 1'b0;
        mem_rw = 1'b0;
        mem_read("rst_wr_word8",  9'd8,   2'b10, 1'b0, 32'd0);
        mem_read("rst_word0",     9'd0,   2'b10, 1'b0, 32'd0);
        mem_read("rst_word510",   9'd510, 2'b10, 1'b0, 32'd0);
        mem_read("rst_byte8_se",  9'd8,   2'b00, 1'b1, 32'd0);

        // Normal writes resume after reset.
        mem_write(9'd100, 32'h8765_4321, 2'b10);
        mem_read("post_rst_wr", 9'd100, 2'b10, 1'b0, 32'h8765_4321);

        $display("%0d/%0d checks passed", n_pass_r, n_checks_r);
        $finish;
    end

endmodule
